// File: rtl/clk_en_meter_pkg.sv
// clk_en_meter_pkg: shared types, default parameters and tolerance-bound helpers for the period meter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: meter_state_t FSM encoding, DEF_* parameter defaults, tol_lo/tol_hi bound functions.
package clk_en_meter_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        MEASURE,
        LOCKED
    } meter_state_t;

    localparam int DEF_WIDTH       = 32;
    localparam int DEF_EXP_DIVISOR = 2;
    localparam int DEF_TOL         = 0;
    localparam int DEF_LOCK_COUNT  = 4;

    // Lower acceptance bound; a period can never be shorter than one cycle,
    // so a negative or zero bound clamps to 1.
    function automatic int tol_lo(input int exp_div, input int tol);
        return ((exp_div - tol) < 1) ? 1 : (exp_div - tol);
    endfunction

    function automatic int tol_hi(input int exp_div, input int tol);
        return exp_div + tol;
    endfunction

endpackage

// File: rtl/strobe_rise_det.sv
// strobe_rise_det: delays the strobe by one cycle and flags its 0->1 transition.
// Latency: rise is combinational from strobe_in against the registered copy.
// Backpressure: none; samples every in_clk cycle.
// Ports: in_clk, reset (sync, active-high), strobe_in, rise (strobe_in & ~delayed strobe).
module strobe_rise_det (
    input  logic in_clk,
    input  logic reset,
    input  logic strobe_in,
    output logic rise
);

    logic s_q;

    always_ff @(posedge in_clk) begin
        if (reset) begin
            s_q <= 1'b0;
        end else begin
            s_q <= strobe_in;
        end
    end

    assign rise = strobe_in & ~s_q;

endmodule

// File: rtl/clk_en_period_meter.sv
// clk_en_period_meter: times rising edges of strobe_in in in_clk cycles, reports lock/range/timeout status.
// Latency: outputs registered; a rise sampled at edge N is reported during cycle N+1.
// Backpressure: none; every edge is measured, pulses last exactly one cycle.
// Ports: in_clk, reset (sync, active-high), enable, strobe_in -> period, period_valid, locked,
//        err_range, timeout. Define CLK_EN_METER_STATS_EN to add period_min / period_max.
module clk_en_period_meter
    import clk_en_meter_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int EXP_DIVISOR = DEF_EXP_DIVISOR,
    parameter int TOL         = DEF_TOL,
    parameter int LOCK_COUNT  = DEF_LOCK_COUNT,
    parameter int TIMEOUT     = 4 * EXP_DIVISOR
) (
    input  logic             in_clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             strobe_in,
    output logic [WIDTH-1:0] period,
    output logic             period_valid,
    output logic             locked,
    output logic             err_range,
    output logic             timeout
`ifdef CLK_EN_METER_STATS_EN
    ,
    output logic [WIDTH-1:0] period_min,
    output logic [WIDTH-1:0] period_max
`endif
);

    localparam logic [WIDTH-1:0] BOUND_LO = WIDTH'(tol_lo(EXP_DIVISOR, TOL));
    localparam logic [WIDTH-1:0] BOUND_HI = WIDTH'(tol_hi(EXP_DIVISOR, TOL));
    localparam logic [WIDTH-1:0] CNT_MAX  = WIDTH'(TIMEOUT);
    localparam int               MW       = $clog2(LOCK_COUNT + 1);
    localparam logic [MW-1:0]    LOCK_N   = MW'(LOCK_COUNT);

    meter_state_t     state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] period_d;
    logic [MW-1:0]    match_q, match_d;
    logic             pv_d, locked_d, err_d, to_d;
    logic             rise, in_tol, at_limit;

    strobe_rise_det u_rise (
        .in_clk    (in_clk),
        .reset     (reset),
        .strobe_in (strobe_in),
        .rise      (rise)
    );

    assign in_tol   = (cnt_q >= BOUND_LO) && (cnt_q <= BOUND_HI);
    assign at_limit = (cnt_q == CNT_MAX);

    always_comb begin
        state_d  = state_q;
        match_d  = match_q;
        period_d = period;
        locked_d = locked;
        pv_d     = 1'b0;
        err_d    = 1'b0;
        to_d     = 1'b0;

        // Free-running spacing counter: restarts at 1 on each edge, saturates at
        // the timeout so a dead strobe cannot wrap into a bogus short period.
        if (rise) begin
            cnt_d = WIDTH'(1);
        end else if (!at_limit) begin
            cnt_d = cnt_q + WIDTH'(1);
        end else begin
            cnt_d = cnt_q;
        end

        if (!enable) begin
            state_d  = IDLE;
            cnt_d    = '0;
            match_d  = '0;
            locked_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = ARM;
                    cnt_d   = '0;
                end
                // First edge only establishes a time reference.
                ARM: begin
                    if (rise) begin
                        state_d = MEASURE;
                    end
                end
                MEASURE: begin
                    if (rise) begin
                        period_d = cnt_q;
                        pv_d     = 1'b1;
                        if (in_tol) begin
                            match_d = match_q + MW'(1);
                            if ((match_q + MW'(1)) == LOCK_N) begin
                                state_d  = LOCKED;
                                locked_d = 1'b1;
                            end
                        end else begin
                            match_d = '0;
                        end
                    end else if (at_limit) begin
                        to_d     = 1'b1;
                        match_d  = '0;
                        locked_d = 1'b0;
                        state_d  = ARM;
                    end
                end
                LOCKED: begin
                    if (rise) begin
                        period_d = cnt_q;
                        pv_d     = 1'b1;
                        if (!in_tol) begin
                            locked_d = 1'b0;
                            match_d  = '0;
                            err_d    = 1'b1;
                            state_d  = MEASURE;
                        end
                    end else if (at_limit) begin
                        to_d     = 1'b1;
                        match_d  = '0;
                        locked_d = 1'b0;
                        state_d  = ARM;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge in_clk) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            match_q      <= '0;
            period       <= '0;
            period_valid <= 1'b0;
            locked       <= 1'b0;
            err_range    <= 1'b0;
            timeout      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            match_q      <= match_d;
            period       <= period_d;
            period_valid <= pv_d;
            locked       <= locked_d;
            err_range    <= err_d;
            timeout      <= to_d;
        end
    end

`ifdef CLK_EN_METER_STATS_EN
    // A zero minimum means "nothing recorded yet": reported periods are always >= 1.
    always_ff @(posedge in_clk) begin
        if (reset || !enable) begin
            period_min <= '0;
            period_max <= '0;
        end else if (pv_d) begin
            if ((period_min == '0) || (period_d < period_min)) begin
                period_min <= period_d;
            end
            if (period_d > period_max) begin
                period_max <= period_d;
            end
        end
    end
`endif

endmodule

// File: tb/tb_clk_en_period_meter.sv
// tb_clk_en_period_meter: directed plus randomized stimulus for clk_en_period_meter.
// Reference model tracks edge timestamps and run lengths; outputs compared every cycle.
// Literal checks at key points of lock-up, range error, timeout, reset and disable.
module tb_clk_en_period_meter;

    localparam int EXP  = 4;
    localparam int TOLR = 0;
    localparam int LOCK = 4;
    localparam int TO   = 16;
    localparam int LO   = ((EXP - TOLR) < 1) ? 1 : (EXP - TOLR);
    localparam int HI   = EXP + TOLR;

    logic        in_clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        strobe_in = 1'b0;
    logic [31:0] period;
    logic        period_valid, locked, err_range, timeout;
`ifdef CLK_EN_METER_STATS_EN
    logic [31:0] period_min, period_max;
`endif

    int checks = 0;
    int failures = 0;
    bit cmp_en = 1'b0;

    // model state
    int unsigned t_now = 0;
    int unsigned m_last_edge = 0;
    int unsigned m_good_run = 0;
    bit          m_prev_s = 1'b0;
    bit          m_awake = 1'b0;
    bit          m_have_ref = 1'b0;
    int unsigned e_period = 0;
    bit          e_pv = 1'b0, e_lk = 1'b0, e_err = 1'b0, e_to = 1'b0;
`ifdef CLK_EN_METER_STATS_EN
    int unsigned e_min = 0, e_max = 0;
`endif

    // values captured right after a rising strobe edge
    logic [31:0] r_per;
    logic        r_pv, r_lk, r_err;

    clk_en_period_meter #(
        .WIDTH       (32),
        .EXP_DIVISOR (EXP),
        .TOL         (TOLR),
        .LOCK_COUNT  (LOCK),
        .TIMEOUT     (TO)
    ) dut (
        .in_clk       (in_clk),
        .reset        (reset),
        .enable       (enable),
        .strobe_in    (strobe_in),
        .period       (period),
        .period_valid (period_valid),
        .locked       (locked),
        .err_range    (err_range),
        .timeout      (timeout)
`ifdef CLK_EN_METER_STATS_EN
        ,
        .period_min   (period_min),
        .period_max   (period_max)
`endif
    );

    initial forever #5 in_clk = ~in_clk;

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
        end
    endtask

    // Apply inputs for one clock edge; returns just after that edge.
    task automatic step(input bit s, input bit en, input bit rst);
        @(negedge in_clk);
        strobe_in = s;
        enable    = en;
        reset     = rst;
        @(posedge in_clk);
        #1;
    endtask

    // One strobe period of n cycles (2 high, n-2 low), capturing outputs after the rise.
    task automatic edge_p(input int n);
        step(1'b1, 1'b1, 1'b0);
        r_per = period;
        r_pv  = period_valid;
        r_lk  = locked;
        r_err = err_range;
        step(1'b1, 1'b1, 1'b0);
        for (int k = 0; k < n - 2; k++) step(1'b0, 1'b1, 1'b0);
    endtask

    // Behavioural reference: periods are timestamp differences, lock is a run
    // length of good periods, timeout is "TO cycles since the last reference edge".
    initial begin : model
        bit          rise;
        int unsigned el;
        forever begin
            @(posedge in_clk);
            rise = strobe_in && !m_prev_s;
            el   = ((t_now - m_last_edge) > TO) ? TO : (t_now - m_last_edge);
            e_pv = 1'b0;
            e_err = 1'b0;
            e_to = 1'b0;
            if (reset) begin
                m_awake = 0; m_have_ref = 0; m_good_run = 0; e_lk = 0; e_period = 0;
`ifdef CLK_EN_METER_STATS_EN
                e_min = 0; e_max = 0;
`endif
            end else if (!enable) begin
                m_awake = 0; m_have_ref = 0; m_good_run = 0; e_lk = 0;
`ifdef CLK_EN_METER_STATS_EN
                e_min = 0; e_max = 0;
`endif
            end else if (!m_awake) begin
                m_awake = 1;
            end else if (rise) begin
                if (m_have_ref) begin
                    e_pv = 1'b1;
                    e_period = el;
                    if (el >= LO && el <= HI) begin
                        m_good_run++;
                        if (m_good_run == LOCK) e_lk = 1'b1;
                    end else begin
                        e_err = e_lk;
                        e_lk = 1'b0;
                        m_good_run = 0;
                    end
`ifdef CLK_EN_METER_STATS_EN
                    if (e_min == 0 || el < e_min) e_min = el;
                    if (el > e_max) e_max = el;
`endif
                end
                m_have_ref = 1'b1;
                m_last_edge = t_now;
            end else if (m_have_ref && (t_now - m_last_edge) == TO) begin
                e_to = 1'b1;
                e_lk = 1'b0;
                m_good_run = 0;
                m_have_ref = 1'b0;
            end
            m_prev_s = reset ? 1'b0 : strobe_in;
            t_now++;
        end
    end

    always @(negedge in_clk) begin
        if (cmp_en) begin
            chk32("period", period, e_period);
            chk1("period_valid", period_valid, e_pv);
            chk1("locked", locked, e_lk);
            chk1("err_range", err_range, e_err);
            chk1("timeout", timeout, e_to);
`ifdef CLK_EN_METER_STATS_EN
            chk32("period_min", period_min, e_min);
            chk32("period_max", period_max, e_max);
`endif
        end
    end

    initial begin
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        cmp_en = 1'b1;
        chk32("rst_period", period, 32'd0);
        chk1("rst_valid", period_valid, 1'b0);
        chk1("rst_locked", locked, 1'b0);
        chk1("rst_err", err_range, 1'b0);
        chk1("rst_timeout", timeout, 1'b0);

        // lock-up
        step(1'b0, 1'b1, 1'b0);
        edge_p(4);
        chk1("first_edge_no_valid", r_pv, 1'b0);
        edge_p(4);
        chk32("lock_period", r_per, 32'd4);
        chk1("lock_valid", r_pv, 1'b1);
        edge_p(4);
        edge_p(4);
        chk1("not_locked_4th_edge", r_lk, 1'b0);
        edge_p(4);
        chk1("locked_5th_edge", r_lk, 1'b1);

        // range error
        edge_p(6);
        chk1("pre_err_locked", r_lk, 1'b1);
        edge_p(4);
        chk32("err_period", r_per, 32'd6);
        chk1("err_pulse", r_err, 1'b1);
        chk1("err_unlock", r_lk, 1'b0);
        repeat (3) edge_p(4);
        chk1("relock_pending", r_lk, 1'b0);
        edge_p(4);
        chk1("relock", r_lk, 1'b1);

        // timeout
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        repeat (14) step(1'b0, 1'b1, 1'b0);
        chk1("no_timeout_15", timeout, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        chk1("timeout_16", timeout, 1'b1);
        chk1("timeout_unlock", locked, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        chk1("timeout_one_cycle", timeout, 1'b0);
        edge_p(4);
        chk1("post_timeout_no_valid", r_pv, 1'b0);
        repeat (4) edge_p(4);
        chk1("relock_after_timeout", r_lk, 1'b1);

        // reset while locked
        step(1'b0, 1'b1, 1'b1);
        chk32("midrst_period", period, 32'd0);
        chk1("midrst_locked", locked, 1'b0);
        chk1("midrst_valid", period_valid, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        repeat (4) edge_p(4);
        chk1("rst_relock_pending", r_lk, 1'b0);
        edge_p(4);
        chk1("rst_relock", r_lk, 1'b1);

        // disable while locked
        step(1'b0, 1'b0, 1'b0);
        chk1("dis_locked", locked, 1'b0);
        chk32("dis_period_held", period, 32'd4);
        step(1'b0, 1'b1, 1'b0);
        edge_p(4);
        chk1("dis_rearm_no_valid", r_pv, 1'b0);

        // periods 4, 5, 3
        edge_p(5);
        edge_p(3);
        edge_p(4);
        chk32("last_period_3", r_per, 32'd3);
`ifdef CLK_EN_METER_STATS_EN
        chk32("stats_min", period_min, 32'd3);
        chk32("stats_max", period_max, 32'd5);
`endif

        // randomized strobe spacing, duty, enable drops and resets
        for (int it = 0; it < 300; it++) begin
            int sel, n, hi;
            sel = $urandom_range(0, 9);
            n = (sel < 6) ? 4 : (sel == 6) ? 3 : (sel == 7) ? 5 : (sel == 8) ? 2 : 18;
            hi = $urandom_range(1, n - 1);
            for (int k = 0; k < n; k++) begin
                step(k < hi, $urandom_range(0, 60) != 0, $urandom_range(0, 150) == 0);
            end
        end

        @(negedge in_clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
